// File: rtl/result_normalizer.sv
// Post-add normalizer: turns a sign/exponent/mantissa triple into a packed IEEE-754 single (truncating, no denormals).
// Optional Overflow/Underflow outputs are compiled in with `define RESULT_NORMALIZER_FLAGS_EN.
module result_normalizer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic        S_In,
  input  logic [7:0]  E_In,
  input  logic [23:0] M_In,
  input  logic        Carry_In,
  output logic [31:0] Result,
  output logic        Done,
  output logic        Busy
`ifdef RESULT_NORMALIZER_FLAGS_EN
  ,
  output logic        Overflow,
  output logic        Underflow
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  logic        s, s_nx;
  logic        c, c_nx;
  logic [7:0]  e, e_nx;
  logic [23:0] m, m_nx;
  logic [31:0] result_nx;

  function automatic logic [31:0] pack(input logic sign, input logic [7:0] exp, input logic [22:0] frac);
    return {sign, exp, frac};
  endfunction

  function automatic logic [31:0] infinity(input logic sign);
    return {sign, 8'hFF, 23'b0};
  endfunction

  function automatic logic [31:0] signed_zero(input logic sign);
    return {sign, 31'b0};
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and datapath updates; result_nx only moves on the edge entering DONE.
  always_comb begin
    state_nx  = state;
    s_nx      = s;
    c_nx      = c;
    e_nx      = e;
    m_nx      = m;
    result_nx = Result;
    unique case (state)
      IDLE: begin
        if (Load) begin
          s_nx     = S_In;
          e_nx     = E_In;
          m_nx     = M_In;
          c_nx     = Carry_In;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        state_nx = DONE;
        if (e == 8'hFF) begin
          result_nx = infinity(s);
        end else if (c) begin
          // Carry renormalizes right by one; the bit shifted out is dropped.
          if (e == 8'hFE) begin
            result_nx = infinity(s);
          end else begin
            e_nx      = e + 8'd1;
            m_nx      = {1'b1, m[23:1]};
            result_nx = pack(s, e + 8'd1, m[23:1]);
          end
        end else if (m == '0 || e == '0) begin
          result_nx = signed_zero(s);
        end else if (m[23]) begin
          result_nx = pack(s, e, m[22:0]);
        end else begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (e == 8'd1) begin
          result_nx = signed_zero(s);
          state_nx  = DONE;
        end else begin
          e_nx = e - 8'd1;
          m_nx = {m[22:0], 1'b0};
          if (m[22]) begin
            result_nx = pack(s, e - 8'd1, {m[21:0], 1'b0});
            state_nx  = DONE;
          end
        end
      end
      DONE: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s      <= 1'b0;
      c      <= 1'b0;
      e      <= '0;
      m      <= '0;
      Result <= '0;
    end else begin
      s      <= s_nx;
      c      <= c_nx;
      e      <= e_nx;
      m      <= m_nx;
      Result <= result_nx;
    end
  end

`ifdef RESULT_NORMALIZER_FLAGS_EN
  // Exponent FF only arises from infinity; a zero reached from SHIFT is always an underflow.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (state_nx == DONE) begin
      Overflow  <= (result_nx[30:23] == 8'hFF);
      Underflow <= (state == SHIFT) && (result_nx[30:0] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_result_normalizer.sv
// Bench for result_normalizer: random traffic against an arithmetic reference model plus directed literal cases.
module tb_result_normalizer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Load = 1'b0;
  logic        S_In = 1'b0;
  logic [7:0]  E_In = '0;
  logic [23:0] M_In = '0;
  logic        Carry_In = 1'b0;
  logic [31:0] Result;
  logic        Done;
  logic        Busy;
`ifdef RESULT_NORMALIZER_FLAGS_EN
  logic        Overflow;
  logic        Underflow;
`endif

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  result_normalizer dut (
    .Clk(Clk),
    .Reset(Reset),
    .Load(Load),
    .S_In(S_In),
    .E_In(E_In),
    .M_In(M_In),
    .Carry_In(Carry_In),
    .Result(Result),
    .Done(Done),
    .Busy(Busy)
`ifdef RESULT_NORMALIZER_FLAGS_EN
    ,
    .Overflow(Overflow),
    .Underflow(Underflow)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  k;
    logic        ovf;
    logic        unf;
  } outcome_t;

  // Outcome of one operation: packed result, number of shift cycles, and flags.
  function automatic outcome_t model(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c);
    outcome_t o;
    int lz;
    o.res = {s, 31'b0};
    o.k   = '0;
    o.ovf = 1'b0;
    o.unf = 1'b0;
    if (e == 8'hFF) begin
      o.res = {s, 8'hFF, 23'b0};
      o.ovf = 1'b1;
    end else if (c) begin
      if (e == 8'hFE) begin
        o.res = {s, 8'hFF, 23'b0};
        o.ovf = 1'b1;
      end else begin
        o.res = {s, 8'(e + 8'd1), m[23:1]};
      end
    end else if (m != 0 && e != 0) begin
      lz = 0;
      while (lz < 23 && !m[23 - lz]) lz++;
      if (lz <= int'(e) - 1) begin
        logic [23:0] mn;
        mn    = m << lz;
        o.k   = 5'(lz);
        o.res = {s, 8'(int'(e) - lz), mn[22:0]};
      end else begin
        o.k   = 5'(e);
        o.unf = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  outcome_t cur, pend, exp_o;
  int cnt = 0;
  bit in_done = 1'b0;
  bit exp_busy;

  always_comb cur = model(S_In, E_In, M_In, Carry_In);
  always_comb exp_busy = (cnt > 0) || in_done;

  // Cycle-level expectation: cnt counts edges until DONE is entered.
  always @(posedge Clk) begin
    if (Reset) begin
      cnt     <= 0;
      in_done <= 1'b0;
      exp_o   <= '0;
    end else if (in_done) begin
      in_done <= 1'b0;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      cnt     <= 0;
      in_done <= 1'b1;
      exp_o   <= pend;
    end else if (Load) begin
      cnt  <= 1 + int'(cur.k);
      pend <= cur;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", {31'b0, Busy}, {31'b0, exp_busy});
      check("done", {31'b0, Done}, {31'b0, in_done});
      check("result", Result, exp_o.res);
`ifdef RESULT_NORMALIZER_FLAGS_EN
      check("overflow", {31'b0, Overflow}, {31'b0, exp_o.ovf});
      check("underflow", {31'b0, Underflow}, {31'b0, exp_o.unf});
`endif
    end
  end

  // Called at a falling edge; returns the number of rising edges from the Load edge to DONE entry.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c, output int lat);
    S_In = s;
    E_In = e;
    M_In = m;
    Carry_In = c;
    Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    lat = 0;
    while (!Done && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    if (!Done) check("timeout_done", {31'b0, Done}, 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    int lat;
    outcome_t o;
    logic [31:0] r;

    o = model(1'b0, 8'h80, 24'hC00000, 1'b1);
    check("model_carry", o.res, 32'h40E00000);
    check("model_carry_k", {27'b0, o.k}, 32'd0);
    o = model(1'b0, 8'h82, 24'h100000, 1'b0);
    check("model_shift3", o.res, 32'h3F800000);
    check("model_shift3_k", {27'b0, o.k}, 32'd3);
    o = model(1'b0, 8'h02, 24'h000001, 1'b0);
    check("model_underflow", o.res, 32'h00000000);
    check("model_underflow_flag", {31'b0, o.unf}, 32'd1);
    o = model(1'b0, 8'hFE, 24'h800000, 1'b1);
    check("model_overflow", o.res, 32'h7F800000);
    check("model_overflow_flag", {31'b0, o.ovf}, 32'd1);

    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    check("reset_result", Result, 32'h0);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_done", {31'b0, Done}, 32'd0);
    Reset = 1'b0;

    run_op(1'b0, 8'h80, 24'hC00000, 1'b1, lat);
    check("carry_result", Result, 32'h40E00000);
    check("carry_latency", lat, 1);
    run_op(1'b1, 8'h7F, 24'h800000, 1'b0, lat);
    check("norm_result", Result, 32'hBF800000);
    check("norm_latency", lat, 1);
    run_op(1'b0, 8'hFE, 24'h800000, 1'b1, lat);
    check("ovf_result", Result, 32'h7F800000);
`ifdef RESULT_NORMALIZER_FLAGS_EN
    check("ovf_flag", {31'b0, Overflow}, 32'd1);
`endif
    run_op(1'b0, 8'h02, 24'h000001, 1'b0, lat);
    check("unf_result", Result, 32'h0);
    check("unf_latency", lat, 3);
`ifdef RESULT_NORMALIZER_FLAGS_EN
    check("unf_flag", {31'b0, Underflow}, 32'd1);
`endif
    run_op(1'b0, 8'h85, 24'h000000, 1'b0, lat);
    check("zero_result", Result, 32'h0);
`ifdef RESULT_NORMALIZER_FLAGS_EN
    check("zero_unf_flag", {31'b0, Underflow}, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      Load = ($urandom_range(0, 2) == 0);
      S_In = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: E_In = 8'h00;
        1: E_In = 8'h01;
        2: E_In = 8'($urandom_range(2, 24));
        3: E_In = 8'hFE;
        4: E_In = 8'hFF;
        default: E_In = 8'($urandom_range(0, 255));
      endcase
      r = $urandom;
      M_In = r[23:0] >> $urandom_range(0, 24);
      Carry_In = ($urandom_range(0, 3) == 0);
      @(negedge Clk);
    end
    Reset = 1'b1;
    Load = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;

    run_op(1'b0, 8'h82, 24'h100000, 1'b0, lat);
    check("shift3_result", Result, 32'h3F800000);
    check("shift3_latency", lat, 4);

    S_In = 1'b0;
    E_In = 8'h82;
    M_In = 24'h100000;
    Carry_In = 1'b0;
    Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_result", Result, 32'h0);
    check("abort_busy", {31'b0, Busy}, 32'd0);
    check("abort_done", {31'b0, Done}, 32'd0);
    repeat (2) @(negedge Clk);
    run_op(1'b0, 8'h82, 24'h100000, 1'b0, lat);
    check("after_abort_result", Result, 32'h3F800000);
    check("after_abort_latency", lat, 4);

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_normalizer.md
RESULT_NORMALIZER -- requirements
Module: result_normalizer

Interface
REQ-001 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port Load  input  1  start request; accepted only when Busy=0.
REQ-004 SHALL have port S_In  input  1  sign from the alignment/add stage.
REQ-005 SHALL have port E_In  input  8  biased exponent from the alignment/add stage.
REQ-006 SHALL have port M_In  input  24  mantissa from the alignment/add stage, hidden bit at [23].
REQ-007 SHALL have port Carry_In  input  1  mantissa-addition carry-out.
REQ-008 SHALL have port Result  output  32  packed IEEE-754 single, {sign, exp[7:0], frac[22:0]}.
REQ-009 SHALL have port Done  output  1  one-cycle pulse; Result is valid from this cycle on.
REQ-010 SHALL have port Busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, CHECK, SHIFT and DONE; Done=1 only in DONE.
REQ-012 IDLE: on Load=1, SHALL capture S_In, E_In, M_In and Carry_In into internal S, E, M, C and go to CHECK; Load is ignored in all other states.
REQ-013 CHECK, priority order: E==8'hFF -> infinity; C=1 -> M={1'b1,M[23:1]}, E=E+1 (E==8'hFE -> infinity); M==0 or E==0 -> signed zero {S,31'b0}; M[23]=1 -> pack; each of these cases goes to DONE. Otherwise the FSM SHALL go to SHIFT.
REQ-014 SHIFT, per cycle: if E==1, SHALL produce signed zero (underflow, no denormals) and go to DONE; else M=M<<1, E=E-1, and go to DONE when the new M[23]=1.
REQ-015 SHALL encode infinity as {S,8'hFF,23'b0}; the truncation rule SHALL discard the bit shifted out on the carry path, with no rounding.
REQ-016 Pack SHALL write Result={S,E,M[22:0]} on the edge entering DONE; Result SHALL hold until the next DONE entry.
REQ-017 Latency: with Load sampled at edge t, DONE SHALL be entered at edge t+1+k, where k = number of SHIFT cycles (0..23); the maximum total is 25 cycles.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE; Load asserted during DONE SHALL be ignored.
REQ-019 Back-to-back operation: a Load in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-020 When Reset=1 at an edge, the block SHALL go to IDLE and set Result=0, Done=0, Busy=0, and clear internal S/E/M/C (plus flags when compiled in).
REQ-021 Reset SHALL take priority over Load and over any in-progress CHECK/SHIFT; the aborted operation SHALL produce no Done.

Configuration
REQ-022 Macro RESULT_NORMALIZER_FLAGS_EN: when defined, the block SHALL add outputs Overflow (1) and Underflow (1), both registered and written on DONE entry.
REQ-023 With the macro, Overflow=1 for an infinity result and Underflow=1 for a REQ-014 zero. Both flags SHALL be 0 for an exact-zero input and SHALL hold until the next DONE entry or Reset.
REQ-024 Without the macro, the block SHALL omit both ports; Result values and timing SHALL be identical.

Verification
REQ-025 Carry path: S=0, E=8'h80, M=24'hC00000, C=1 -> Result=32'h40E00000, Done after edge t+1.
REQ-026 Already normalized: S=1, E=8'h7F, M=24'h800000, C=0 -> Result=32'hBF800000, Done after edge t+1, k=0.
REQ-027 Three-bit shift: S=0, E=8'h82, M=24'h100000, C=0 -> Result=32'h3F800000, Done after edge t+4, with Busy high throughout.
REQ-028 Overflow: S=0, E=8'hFE, M=24'h800000, C=1 -> Result=32'h7F800000 and Overflow=1 (macro on); same Result with macro off.
REQ-029 Underflow and zero: E=8'h02, M=24'h000001 -> Result=32'h00000000, Underflow=1. E=8'h85, M=0 -> Result=0, Underflow=0.
REQ-030 Reset in SHIFT: start REQ-027 and assert Reset at edge t+2 -> Result=0, Busy=0, no Done pulse; a Load at edge t+5 is accepted normally.
